dmx_rx: RTL

- DMX512 receiver: the opposite end of the team's DMX transmitter.
- Oversamples the RS-485 line and detects break and mark-after-break (MAB).
- Deserialises 8N2 slots, then presents the start code and per-channel bytes (channels 1..512) to downstream logic as single-cycle strobes.
- Sits between the RS-485 transceiver input pin and the channel register file / fixture logic.

---
 rtl/dmx_rx.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dmx_rx.sv
// dmx_rx: DMX512 receiver.
// The line is synchronised and oversampled. A break and a mark-after-break
// arm the receiver. Each 8N2 slot is then deserialised at its bit centres.
// The start code and the channel bytes leave as single-cycle strobes.
module dmx_rx #(
    parameter int unsigned OVERSAMPLE     = 16,
    parameter int unsigned BREAK_MIN_BITS = 22,
    parameter int unsigned MAB_MIN_BITS   = 2,
    parameter logic [7:0]  START_CODE     = 8'h00
) (
    input  logic       dmxclk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] start_code,
    output logic       start_valid,
    output logic [8:0] chan_addr,
    output logic [7:0] chan_data,
    output logic       chan_valid,
    output logic       frame_done,
    output logic [9:0] slot_count,
    output logic       framing_err,
    output logic       receiving
);

    localparam int unsigned BRK_CYC = BREAK_MIN_BITS * OVERSAMPLE;
    localparam int unsigned MAB_CYC = MAB_MIN_BITS * OVERSAMPLE;
    localparam int unsigned CW      = $clog2(BRK_CYC + 1);

    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] BRK_LAST  = CW'(BRK_CYC - 1);
    localparam logic [CW-1:0] BRK_SAT   = CW'(BRK_CYC);
    // BREAK consumes the first high cycle, so MAB needs one cycle fewer.
    localparam logic [CW-1:0] MAB_LAST  = CW'(MAB_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [9:0]    LAST_SLOT = 10'd512;

    typedef enum logic [2:0] {
        S_WAIT_BREAK,
        S_BREAK,
        S_MAB,
        S_START,
        S_DATA,
        S_STOP,
        S_MARK
    } state_t;

    logic          sync1_q, rxs_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] low_cnt_q, low_cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    byte_q, byte_d;
    logic [9:0]    slot_q, slot_d;
    logic [7:0]    start_code_q, start_code_d;
    logic          start_valid_q, start_valid_d;
    logic [8:0]    chan_addr_q, chan_addr_d;
    logic [7:0]    chan_data_q, chan_data_d;
    logic          chan_valid_q, chan_valid_d;
    logic          frame_done_q, frame_done_d;
    logic [9:0]    slot_count_q, slot_count_d;
    logic          framing_err_q, framing_err_d;
    logic          receiving_q, receiving_d;
    logic [9:0]    chans_s;
    logic          brk_hit_s;

    // Channels completed so far: every finished slot except the start code.
    assign chans_s   = (slot_q == 10'd0) ? 10'd0 : (slot_q - 10'd1);
    // Fires once, on the cycle the low run reaches break length.
    assign brk_hit_s = !rxs_q && (low_cnt_q == BRK_LAST);

    // Two-flop synchroniser for the asynchronous line; idles at mark.
    always_ff @(posedge dmxclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rx;
            rxs_q   <= sync1_q;
        end
    end

    // State, counters, datapath and registered outputs.
    always_ff @(posedge dmxclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_WAIT_BREAK;
            cnt_q         <= '0;
            low_cnt_q     <= '0;
            bit_q         <= 3'd0;
            byte_q        <= 8'h00;
            slot_q        <= 10'd0;
            start_code_q  <= 8'h00;
            start_valid_q <= 1'b0;
            chan_addr_q   <= 9'd0;
            chan_data_q   <= 8'h00;
            chan_valid_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            slot_count_q  <= 10'd0;
            framing_err_q <= 1'b0;
            receiving_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            low_cnt_q     <= low_cnt_d;
            bit_q         <= bit_d;
            byte_q        <= byte_d;
            slot_q        <= slot_d;
            start_code_q  <= start_code_d;
            start_valid_q <= start_valid_d;
            chan_addr_q   <= chan_addr_d;
            chan_data_q   <= chan_data_d;
            chan_valid_q  <= chan_valid_d;
            frame_done_q  <= frame_done_d;
            slot_count_q  <= slot_count_d;
            framing_err_q <= framing_err_d;
            receiving_q   <= receiving_d;
        end
    end

    // Break detector plus slot FSM; a detected break overrides every state.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        byte_d        = byte_q;
        slot_d        = slot_q;
        start_code_d  = start_code_q;
        start_valid_d = 1'b0;
        chan_addr_d   = chan_addr_q;
        chan_data_d   = chan_data_q;
        chan_valid_d  = 1'b0;
        frame_done_d  = 1'b0;
        slot_count_d  = slot_count_q;
        framing_err_d = 1'b0;
        receiving_d   = receiving_q;

        if (rxs_q) begin
            low_cnt_d = '0;
        end else if (low_cnt_q == BRK_SAT) begin
            low_cnt_d = low_cnt_q;
        end else begin
            low_cnt_d = low_cnt_q + CNT_ONE;
        end

        if (brk_hit_s) begin
            state_d = S_BREAK;
            cnt_d   = '0;
            if (receiving_q) begin
                frame_done_d = 1'b1;
                slot_count_d = chans_s;
                receiving_d  = 1'b0;
            end else begin
                receiving_d  = 1'b0;
            end
        end else begin
            case (state_q)
                S_WAIT_BREAK: begin
                    state_d = S_WAIT_BREAK;
                end
                S_BREAK: begin
                    if (rxs_q) begin
                        state_d = S_MAB;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_BREAK;
                    end
                end
                S_MAB: begin
                    if (rxs_q) begin
                        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
                    end else if (cnt_q >= MAB_LAST) begin
                        receiving_d = 1'b1;
                        slot_d      = 10'd0;
                        cnt_d       = '0;
                        state_d     = S_START;
                    end else begin
                        state_d     = S_WAIT_BREAK;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_d   = '0;
                        bit_d   = 3'd0;
                        // A high at the start-bit centre was a glitch.
                        state_d = rxs_q ? S_MARK : S_DATA;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d  = '0;
                        byte_d = {rxs_q, byte_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_d = S_STOP;
                        end else begin
                            bit_d   = bit_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (cnt_q != BIT_LAST) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else if (!rxs_q) begin
                        cnt_d         = '0;
                        framing_err_d = 1'b1;
                        frame_done_d  = 1'b1;
                        slot_count_d  = chans_s;
                        receiving_d   = 1'b0;
                        state_d       = S_WAIT_BREAK;
                    end else begin
                        cnt_d = '0;
                        if (slot_q == 10'd0) begin
                            start_code_d  = byte_q;
                            start_valid_d = 1'b1;
                        end else if (start_code_q == START_CODE) begin
                            chan_addr_d  = slot_q[8:0] - 9'd1;
                            chan_data_d  = byte_q;
                            chan_valid_d = 1'b1;
                        end else begin
                            chan_valid_d = 1'b0;
                        end
                        if (slot_q == LAST_SLOT) begin
                            frame_done_d = 1'b1;
                            slot_count_d = LAST_SLOT;
                            receiving_d  = 1'b0;
                            state_d      = S_WAIT_BREAK;
                        end else begin
                            slot_d  = slot_q + 10'd1;
                            state_d = S_MARK;
                        end
                    end
                end
                S_MARK: begin
                    if (!rxs_q) begin
                        cnt_d   = '0;
                        state_d = S_START;
                    end else begin
                        state_d = S_MARK;
                    end
                end
                default: begin
                    state_d     = S_WAIT_BREAK;
                    receiving_d = 1'b0;
                end
            endcase
        end
    end

    assign start_code  = start_code_q;
    assign start_valid = start_valid_q;
    assign chan_addr   = chan_addr_q;
    assign chan_data   = chan_data_q;
    assign chan_valid  = chan_valid_q;
    assign frame_done  = frame_done_q;
    assign slot_count  = slot_count_q;
    assign framing_err = framing_err_q;
    assign receiving   = receiving_q;

endmodule
